// File: rtl/return_address_stack_pkg.sv
// rtl/return_address_stack_pkg.sv - shared RAS types and sizes
// RAS_TOP_RESTORE_EN adds the top-entry address to RAS_Checkpoint.
package return_address_stack_pkg;

   localparam int RAS_DEPTH    = 16;
   localparam int RAS_PTR_BITS = $clog2(RAS_DEPTH);
   localparam int RAS_CNT_BITS = $clog2(RAS_DEPTH) + 1;
   localparam int PC_WIDTH     = 32;

   typedef logic [PC_WIDTH-1:0]     PC_Path;
   typedef logic [RAS_PTR_BITS-1:0] RAS_PtrPath;
   typedef logic [RAS_CNT_BITS-1:0] RAS_CountPath;

   typedef struct packed {
      RAS_PtrPath   topPtr;
      RAS_CountPath count;
`ifdef RAS_TOP_RESTORE_EN
      PC_Path       topAddr;
`endif
   } RAS_Checkpoint;

   // Occupancy saturates at RAS_DEPTH; the oldest entry is silently lost.
   function automatic RAS_CountPath ras_count_inc(input RAS_CountPath c);
      return (c == RAS_CNT_BITS'(RAS_DEPTH)) ? c : c + 1'b1;
   endfunction

endpackage

// File: rtl/return_address_stack_if.sv
// rtl/return_address_stack_if.sv - fetch-side RAS interface
// Checkpoint layout depends on RAS_TOP_RESTORE_EN.
interface return_address_stack_if;
   import return_address_stack_pkg::*;

   logic          stall;
   logic          push;
   PC_Path        pushAddr;
   logic          pop;
   PC_Path        topAddr;
   logic          topValid;
   RAS_Checkpoint ckptOut;
   logic          recover;
   RAS_Checkpoint recoverCkpt;

   modport master (
      output stall, push, pushAddr, pop, recover, recoverCkpt,
      input  topAddr, topValid, ckptOut
   );

   modport slave (
      input  stall, push, pushAddr, pop, recover, recoverCkpt,
      output topAddr, topValid, ckptOut
   );

endinterface

// File: rtl/return_address_stack.sv
// rtl/return_address_stack.sv - circular return-address stack with checkpoint repair
// RAS_TOP_RESTORE_EN: recovery also rewrites the checkpointed top entry.
module return_address_stack
   import return_address_stack_pkg::*;
(
   input logic                   clk,
   input logic                   rst,
   return_address_stack_if.slave ras
);

   PC_Path        stack [RAS_DEPTH];
   RAS_PtrPath    top_ptr;
   RAS_CountPath  count;
   RAS_Checkpoint ckpt;

   logic       wr_en;
   RAS_PtrPath wr_idx;
   PC_Path     wr_data;

   // One write port: recovery restore, or a push / push+pop replace.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = top_ptr;
      wr_data = ras.pushAddr;
      if (ras.recover) begin
`ifdef RAS_TOP_RESTORE_EN
         wr_en   = 1'b1;
         wr_idx  = ras.recoverCkpt.topPtr;
         wr_data = ras.recoverCkpt.topAddr;
`endif
      end else if (!ras.stall && ras.push) begin
         wr_en  = 1'b1;
         wr_idx = ras.pop ? top_ptr : top_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         top_ptr <= RAS_PtrPath'(RAS_DEPTH - 1);
         count   <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            stack[i] <= '0;
         end
      end else begin
         if (wr_en) begin
            stack[wr_idx] <= wr_data;
         end
         if (ras.recover) begin
            top_ptr <= ras.recoverCkpt.topPtr;
            count   <= ras.recoverCkpt.count;
         end else if (!ras.stall) begin
            if (ras.push && !ras.pop) begin
               top_ptr <= top_ptr + 1'b1;
               count   <= ras_count_inc(count);
            end else if (ras.pop && !ras.push && count != '0) begin
               top_ptr <= top_ptr - 1'b1;
               count   <= count - 1'b1;
            end
         end
      end
   end

   always_comb begin
      ckpt        = '0;
      ckpt.topPtr = top_ptr;
      ckpt.count  = count;
`ifdef RAS_TOP_RESTORE_EN
      ckpt.topAddr = stack[top_ptr];
`endif
   end

   assign ras.topAddr  = stack[top_ptr];
   assign ras.topValid = (count != '0);
   assign ras.ckptOut  = ckpt;

endmodule

// File: tb/tb_return_address_stack.sv
// tb/tb_return_address_stack.sv - directed vectors plus overflow/recovery sequences
// Expected recovery target follows RAS_TOP_RESTORE_EN.
module tb_return_address_stack;
   import return_address_stack_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   return_address_stack_if bus ();
   return_address_stack dut (.clk(clk), .rst(rst), .ras(bus));

   typedef struct {
      logic        stall;
      logic        push;
      logic        pop;
      logic [31:0] addr;
      logic [31:0] e_top;
      logic        e_valid;
      int          e_ptr;
      int          e_cnt;
   } vec_t;

   vec_t vt [15];
   int   total = 0;
   int   passed = 0;

`ifdef RAS_TOP_RESTORE_EN
   localparam logic [31:0] EXP_REC = 32'h2000;
`else
   localparam logic [31:0] EXP_REC = 32'h9000;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic check_state(input string tag, input logic [31:0] e_top, input logic e_valid,
                              input int e_ptr, input int e_cnt);
      check({tag, "_top"},   bus.topAddr, e_top);
      check({tag, "_valid"}, 32'(bus.topValid), 32'(e_valid));
      check({tag, "_ptr"},   32'(bus.ckptOut.topPtr), 32'(e_ptr));
      check({tag, "_cnt"},   32'(bus.ckptOut.count), 32'(e_cnt));
   endtask

   task automatic drive(input logic st, input logic pu, input logic po, input logic rc,
                        input logic [31:0] addr);
      bus.stall    = st;
      bus.push     = pu;
      bus.pop      = po;
      bus.recover  = rc;
      bus.pushAddr = addr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      RAS_Checkpoint ck;

      vt[0]  = '{0, 0, 1, 32'h0,    32'h0,    0, 15, 0};
      vt[1]  = '{0, 1, 0, 32'h1000, 32'h1000, 1, 0,  1};
      vt[2]  = '{0, 1, 0, 32'h2000, 32'h2000, 1, 1,  2};
      vt[3]  = '{0, 1, 0, 32'h3000, 32'h3000, 1, 2,  3};
      vt[4]  = '{0, 0, 1, 32'h0,    32'h2000, 1, 1,  2};
      vt[5]  = '{0, 0, 1, 32'h0,    32'h1000, 1, 0,  1};
      vt[6]  = '{0, 0, 1, 32'h0,    32'h0,    0, 15, 0};
      vt[7]  = '{0, 0, 1, 32'h0,    32'h0,    0, 15, 0};
      vt[8]  = '{1, 1, 0, 32'hdead, 32'h0,    0, 15, 0};
      vt[9]  = '{0, 1, 1, 32'h7777, 32'h7777, 0, 15, 0};
      vt[10] = '{0, 1, 0, 32'h1000, 32'h1000, 1, 0,  1};
      vt[11] = '{0, 1, 0, 32'h2000, 32'h2000, 1, 1,  2};
      vt[12] = '{0, 1, 1, 32'h5000, 32'h5000, 1, 1,  2};
      vt[13] = '{0, 0, 1, 32'h0,    32'h1000, 1, 0,  1};
      vt[14] = '{0, 0, 1, 32'h0,    32'h7777, 0, 15, 0};

      ck = '0;
      bus.recoverCkpt = '0;
      drive(0, 1, 0, 0, 32'hffff);
      rst = 1'b0;
      tick();
      tick();
      check_state("reset", 32'h0, 1'b0, 15, 0);
      rst = 1'b1;

      foreach (vt[i]) begin
         drive(vt[i].stall, vt[i].push, vt[i].pop, 1'b0, vt[i].addr);
         tick();
         check_state($sformatf("vec%0d", i), vt[i].e_top, vt[i].e_valid, vt[i].e_ptr, vt[i].e_cnt);
      end

      // Overflow: 17 pushes into a 16-deep stack, then drain 16.
      for (int k = 1; k <= 17; k++) begin
         drive(0, 1, 0, 0, 32'(k * 32'h100));
         tick();
         check_state($sformatf("ovf_push%0d", k), 32'(k * 32'h100), 1'b1,
                     (15 + k) % 16, (k > 16) ? 16 : k);
      end
      for (int j = 0; j < 16; j++) begin
         drive(0, 0, 1, 0, 32'h0);
         check($sformatf("ovf_pop%0d_top", j), bus.topAddr, 32'((17 - j) * 32'h100));
         check($sformatf("ovf_pop%0d_valid", j), 32'(bus.topValid), 32'd1);
         tick();
      end
      check_state("ovf_empty", 32'h1100, 1'b0, 0, 0);

      // Recovery after a wrong-path pop + push.
      drive(0, 1, 0, 0, 32'h1000);
      tick();
      drive(0, 1, 0, 0, 32'h2000);
      tick();
      check_state("rec_setup", 32'h2000, 1'b1, 2, 2);
      ck.topPtr = RAS_PtrPath'(2);
      ck.count  = RAS_CountPath'(2);
`ifdef RAS_TOP_RESTORE_EN
      ck.topAddr = 32'h2000;
      check("ckpt_addr", bus.ckptOut.topAddr, 32'h2000);
`endif
      drive(0, 0, 1, 0, 32'h0);
      tick();
      check_state("rec_wp_pop", 32'h1000, 1'b1, 1, 1);
      drive(0, 1, 0, 0, 32'h9000);
      tick();
      check_state("rec_wp_push", 32'h9000, 1'b1, 2, 2);
      bus.recoverCkpt = ck;
      drive(0, 0, 0, 1, 32'h0);
      tick();
      check_state("rec_done", EXP_REC, 1'b1, 2, 2);

      // Checkpoint reflects pre-update state; recover dominates stall and push.
      drive(0, 1, 0, 0, 32'ha000);
      #1;
      check("ckpt_pre_ptr", 32'(bus.ckptOut.topPtr), 32'd2);
      tick();
      check_state("prio_setup", 32'ha000, 1'b1, 3, 3);
      drive(1, 1, 0, 1, 32'hbbbb);
      tick();
      check_state("prio_rec", EXP_REC, 1'b1, 2, 2);
      drive(1, 1, 0, 0, 32'hcccc);
      tick();
      check_state("prio_stall", EXP_REC, 1'b1, 2, 2);

      // Asynchronous reset mid-cycle, no clock edge in between.
      drive(0, 0, 0, 0, 32'h0);
      #2;
      rst = 1'b0;
      #1;
      check_state("async_rst", 32'h0, 1'b0, 15, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
